// File: rtl/multi_channel_limit_counter.sv
// Bank of independent up/down limit counters with auto-reload or one-shot mode,
// per-channel terminal flag, wrap pulse, sticky overflow and done flags.
module multi_channel_limit_counter #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       down,
    input  logic [CHANNELS-1:0]       one_shot,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] Q,
    output logic [CHANNELS-1:0]       terminal,
    output logic [CHANNELS-1:0]       ovf_pulse,
    output logic [CHANNELS-1:0]       ovf_sticky,
    output logic [CHANNELS-1:0]       done
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] lim;
        logic [WIDTH-1:0] start;
        logic [WIDTH-1:0] cnt;
        logic             term;
        logic             wrap;
        logic             pulse_r;
        logic             sticky_r;
        logic             done_r;

        assign lim   = limit[i*WIDTH +: WIDTH];
        assign start = down[i] ? lim : '0;
        // Up mode uses >= so a limit lowered below the count still terminates.
        assign term  = down[i] ? (cnt == '0) : (cnt >= lim);
        assign wrap  = ~load[i] & en[i] & ~done_r & term;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                pulse_r  <= 1'b0;
                sticky_r <= 1'b0;
                done_r   <= 1'b0;
            end else begin
                pulse_r  <= wrap;
                sticky_r <= wrap | (sticky_r & ~ovf_clr[i]);
                if (load[i]) begin
                    cnt    <= start;
                    done_r <= 1'b0;
                end else if (en[i] && !done_r) begin
                    if (!term) begin
                        cnt <= down[i] ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
                    end else if (one_shot[i]) begin
                        done_r <= 1'b1;
                    end else begin
                        cnt <= start;
                    end
                end
            end
        end

        assign Q[i*WIDTH +: WIDTH] = cnt;
        assign terminal[i]         = term;
        assign ovf_pulse[i]        = pulse_r;
        assign ovf_sticky[i]       = sticky_r;
        assign done[i]             = done_r;
    end

endmodule

// File: tb/tb_multi_channel_limit_counter.sv
// Self-checking bench for multi_channel_limit_counter (WIDTH=8, CHANNELS=2):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_multi_channel_limit_counter;
    localparam int W = 8;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [C-1:0]   en, down, one_shot, load, ovf_clr;
    logic [C*W-1:0] limit;
    logic [C*W-1:0] Q;
    logic [C-1:0]   terminal, ovf_pulse, ovf_sticky, done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int unsigned mq[C];
    bit          md[C], ms[C], mp[C];

    multi_channel_limit_counter #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk(clk), .rst(rst), .en(en), .limit(limit), .down(down),
        .one_shot(one_shot), .load(load), .ovf_clr(ovf_clr), .Q(Q),
        .terminal(terminal), .ovf_pulse(ovf_pulse), .ovf_sticky(ovf_sticky),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic int dq(int c);
        return int'(Q[c*W +: W]);
    endfunction

    function automatic int mlim(int c);
        return int'(limit[c*W +: W]);
    endfunction

    function automatic bit mterm(int c);
        if (down[c]) return mq[c] == 0;
        return mq[c] >= mlim(c);
    endfunction

    task automatic set_lim(int c, int v);
        limit[c*W +: W] = W'(v);
    endtask

    task automatic model_reset();
        for (int c = 0; c < C; c++) begin
            mq[c] = 0; md[c] = 0; ms[c] = 0; mp[c] = 0;
        end
    endtask

    // Advance the model by the rules of operation, then clock the DUT.
    task automatic tick();
        int unsigned nq[C];
        bit nd[C], ns[C], np[C];
        for (int c = 0; c < C; c++) begin
            int  st;
            bit  wrap;
            st   = down[c] ? mlim(c) : 0;
            wrap = !load[c] && en[c] && !md[c] && mterm(c);
            nq[c] = mq[c]; nd[c] = md[c];
            np[c] = wrap;
            ns[c] = wrap || (ms[c] && !ovf_clr[c]);
            if (load[c]) begin
                nq[c] = st; nd[c] = 0;
            end else if (wrap) begin
                if (one_shot[c]) nd[c] = 1;
                else nq[c] = st;
            end else if (en[c] && !md[c]) begin
                nq[c] = down[c] ? (mq[c] + 255) % 256 : (mq[c] + 1) % 256;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < C; c++) begin
            mq[c] = nq[c]; md[c] = nd[c]; ms[c] = ns[c]; mp[c] = np[c];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; down = '0; one_shot = '0; load = '0; ovf_clr = '0; limit = '0;
        #2;
        n_cmp++;
        if (Q !== '0) begin n_fail++; $display("FAIL reset_q: got %h want 0", Q); end
        n_cmp++;
        if ({ovf_pulse, ovf_sticky, done} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0", {ovf_pulse, ovf_sticky, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if (Q !== '0) begin n_fail++; $display("FAIL reset_q_hold: got %h want 0", Q); end
    endtask

    task automatic test_up_reload();
        int exp_q[5] = '{1, 2, 3, 0, 1};
        bit exp_p[5] = '{0, 0, 0, 1, 0};
        set_lim(0, 3); en = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (dq(0) !== exp_q[k]) begin n_fail++; $display("FAIL up_q[%0d]: got %0d want %0d", k, dq(0), exp_q[k]); end
            n_cmp++;
            if ({terminal[0], ovf_pulse[0], ovf_sticky[0]} !== {exp_q[k] == 3, exp_p[k], k >= 3}) begin
                n_fail++;
                $display("FAIL up_flags[%0d]: got %b want %b", k, {terminal[0], ovf_pulse[0], ovf_sticky[0]},
                         {exp_q[k] == 3, exp_p[k], k >= 3});
            end
        end
        en = '0;
    endtask

    task automatic test_down_oneshot();
        set_lim(1, 5); down[1] = 1'b1; one_shot[1] = 1'b1; load = 2'b10;
        tick();
        n_cmp++;
        if (dq(1) !== 5 || done[1] !== 1'b0) begin n_fail++; $display("FAIL ds_load: got q=%0d done=%b want 5/0", dq(1), done[1]); end
        load = '0; en = 2'b10;
        for (int k = 4; k >= 0; k--) begin
            tick();
            n_cmp++;
            if (dq(1) !== k || terminal[1] !== (k == 0)) begin
                n_fail++; $display("FAIL ds_q: got q=%0d term=%b want %0d/%b", dq(1), terminal[1], k, k == 0);
            end
        end
        tick();
        n_cmp++;
        if ({dq(1) == 0, done[1], ovf_pulse[1]} !== 3'b111) begin
            n_fail++; $display("FAIL ds_stop: got q=%0d done=%b pulse=%b want 0/1/1", dq(1), done[1], ovf_pulse[1]);
        end
        tick();
        n_cmp++;
        if ({dq(1) == 0, done[1], ovf_pulse[1]} !== 3'b110) begin
            n_fail++; $display("FAIL ds_held: got q=%0d done=%b pulse=%b want 0/1/0", dq(1), done[1], ovf_pulse[1]);
        end
        n_cmp++;
        if (dq(0) !== 1 || ovf_sticky[0] !== 1'b1) begin
            n_fail++; $display("FAIL ds_ch0_indep: got q=%0d sticky=%b want 1/1", dq(0), ovf_sticky[0]);
        end
        load = 2'b10;
        tick();
        n_cmp++;
        if (dq(1) !== 5 || done[1] !== 1'b0) begin n_fail++; $display("FAIL ds_reload: got q=%0d done=%b want 5/0", dq(1), done[1]); end
        load = '0; en = '0;
    endtask

    task automatic test_sticky();
        ovf_clr = 2'b01;
        tick();
        n_cmp++;
        if (ovf_sticky[0] !== 1'b0) begin n_fail++; $display("FAIL sticky_clr: got %b want 0", ovf_sticky[0]); end
        set_lim(0, 0); en = 2'b01;
        tick();
        n_cmp++;
        if ({dq(0) == 0, ovf_pulse[0], ovf_sticky[0]} !== 3'b111) begin
            n_fail++; $display("FAIL sticky_set_wins: got q=%0d pulse=%b sticky=%b want 0/1/1", dq(0), ovf_pulse[0], ovf_sticky[0]);
        end
        ovf_clr = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (dq(0) !== 0 || ovf_pulse[0] !== 1'b1) begin
                n_fail++; $display("FAIL lim0[%0d]: got q=%0d pulse=%b want 0/1", k, dq(0), ovf_pulse[0]);
            end
        end
        en = '0;
        tick();
        n_cmp++;
        if (ovf_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL lim0_idle: got pulse=%b want 0", ovf_pulse[0]); end
    endtask

    task automatic test_limit_change();
        set_lim(0, 20); load = 2'b01;
        tick();
        load = '0; en = 2'b01;
        repeat (10) tick();
        n_cmp++;
        if (dq(0) !== 10) begin n_fail++; $display("FAIL lc_q10: got %0d want 10", dq(0)); end
        set_lim(0, 4);
        tick();
        n_cmp++;
        if (dq(0) !== 0 || ovf_pulse[0] !== 1'b1) begin
            n_fail++; $display("FAIL lc_wrap: got q=%0d pulse=%b want 0/1", dq(0), ovf_pulse[0]);
        end
        en = '0;
    endtask

    task automatic test_priority();
        set_lim(0, 3); load = 2'b01;
        tick();
        load = '0; en = 2'b01;
        repeat (3) tick();
        n_cmp++;
        if (dq(0) !== 3 || terminal[0] !== 1'b1) begin n_fail++; $display("FAIL pr_term: got q=%0d term=%b want 3/1", dq(0), terminal[0]); end
        load = 2'b01;
        tick();
        n_cmp++;
        if (dq(0) !== 0 || ovf_pulse[0] !== 1'b0) begin
            n_fail++; $display("FAIL pr_load_wins: got q=%0d pulse=%b want 0/0", dq(0), ovf_pulse[0]);
        end
        load = '0;
        repeat (2) tick();
        en = '0;
        repeat (2) tick();
        n_cmp++;
        if (dq(0) !== 2) begin n_fail++; $display("FAIL pr_hold: got %0d want 2", dq(0)); end
        n_cmp++;
        if ({dq(1) == 5, ovf_sticky[1], done[1]} !== 3'b110) begin
            n_fail++; $display("FAIL pr_ch1_indep: got q=%0d sticky=%b done=%b want 5/1/0", dq(1), ovf_sticky[1], done[1]);
        end
    endtask

    task automatic test_async_reset();
        set_lim(0, 20); set_lim(1, 2); load = 2'b11;
        tick();
        load = '0; en = 2'b11;
        repeat (7) tick();
        n_cmp++;
        if (dq(0) !== 7 || done[1] !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got q0=%0d done1=%b want 7/1", dq(0), done[1]); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({Q, ovf_pulse, ovf_sticky, done} !== '0) begin
            n_fail++; $display("FAIL ar_zero: got %h want 0", {Q, ovf_pulse, ovf_sticky, done});
        end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0; en = 2'b01;
        tick();
        n_cmp++;
        if (dq(0) !== 1 || dq(1) !== 0 || done[1] !== 1'b0) begin
            n_fail++; $display("FAIL ar_resume: got q0=%0d q1=%0d done1=%b want 1/0/0", dq(0), dq(1), done[1]);
        end
        en = '0;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < C; c++) begin
                en[c]      = ($urandom_range(0, 3) != 0);
                load[c]    = ($urandom_range(0, 9) == 0);
                ovf_clr[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) down[c] = ~down[c];
                if ($urandom_range(0, 15) == 0) one_shot[c] = ~one_shot[c];
                if ($urandom_range(0, 7) == 0)
                    set_lim(c, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 10));
            end
            tick();
            for (int c = 0; c < C; c++) begin
                n_cmp++;
                if (dq(c) !== int'(mq[c])) begin
                    n_fail++; $display("FAIL rand_q ch%0d cyc%0d: got %0d want %0d", c, cyc, dq(c), mq[c]);
                end
                n_cmp++;
                if ({terminal[c], ovf_pulse[c], ovf_sticky[c], done[c]} !== {mterm(c), mp[c], ms[c], md[c]}) begin
                    n_fail++;
                    $display("FAIL rand_flags ch%0d cyc%0d: got %b want %b", c, cyc,
                             {terminal[c], ovf_pulse[c], ovf_sticky[c], done[c]}, {mterm(c), mp[c], ms[c], md[c]});
                end
            end
        end
        en = '0; load = '0; ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_up_reload();
        test_down_oneshot();
        test_sticky();
        test_limit_change();
        test_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_channel_limit_counter.md
# multi_channel_limit_counter

Parametrised bank of independent limit counters: each channel counts up (0 to limit) or down (limit to 0) on its enable, with auto-reload or one-shot mode. Each channel provides a terminal-count flag, a one-cycle overflow pulse, a software-clearable sticky overflow flag and a one-shot done flag. It serves as the processor's general timer/delay resource, for example as a peripheral behind the memory-mapped I/O decode. All channels share one clock and reset; channel i occupies bit i of each per-channel vector and bits [i*WIDTH +: WIDTH] of each flattened word bus.

## Interface
- WIDTH, 32, counter and limit width in bits (≥2)
- CHANNELS, 2, number of independent channels (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  CHANNELS  count enable per channel
- limit  in  CHANNELS*WIDTH  terminal/reload value per channel, sampled every cycle
- down  in  CHANNELS  0 = count up, 1 = count down
- one_shot  in  CHANNELS  0 = auto-reload, 1 = stop at terminal
- load  in  CHANNELS  synchronous restart to start value
- ovf_clr  in  CHANNELS  clears sticky overflow
- Q  out  CHANNELS*WIDTH  current count
- terminal  out  CHANNELS  combinational: up mode Q ≥ limit; down mode Q == 0
- ovf_pulse  out  CHANNELS  registered, one cycle high after each wrap event
- ovf_sticky  out  CHANNELS  registered, set by wrap event, held until ovf_clr
- done  out  CHANNELS  registered, one-shot channel has stopped

## Operation
- Start value per channel: 0 when down=0, limit when down=1.
- Per channel at each clk edge, in priority order:
  - load=1: Q ← start value; done ← 0. No wrap event.
  - en=1, done=0, terminal=0: Q ← Q+1 (up) or Q−1 (down), modulo 2^WIDTH.
  - en=1, done=0, terminal=1 (wrap event): auto-reload gives Q ← start value; one-shot gives Q held and done ← 1.
  - Otherwise Q is held.
- ovf_pulse ← wrap event, every cycle.
- ovf_sticky ← wrap event, or (ovf_sticky and not ovf_clr). Set wins over a simultaneous clear.
- terminal uses ≥ in up mode, so lowering limit below Q mid-count produces a wrap on the next enabled cycle instead of a run to 2^WIDTH−1.
- Changing down mid-count keeps Q; counting continues in the new direction from Q.
- Changing one_shot while done=1 does not clear done; only load or rst clears it.
- limit=0: every enabled cycle is a wrap event and Q stays 0.
- Channels are fully independent. No cross-channel interaction or shared state beyond clk/rst.

## Timing
- rst asserted (asynchronous): Q=0, ovf_pulse=0, ovf_sticky=0, done=0 on all channels immediately, held while rst=1.
- After reset a down-mode channel sits at Q=0 with terminal=1. Software issues load before enabling; otherwise the first enabled cycle is a wrap event.
- Q, ovf_pulse, ovf_sticky and done update one cycle after the sampled inputs. terminal follows Q and limit combinationally, with the same cycle as Q.
- Up auto-reload period = limit+1 enabled cycles. ovf_pulse is high in the cycle Q shows the reloaded value.
- rst mid-count aborts immediately. No wrap event or pulse is produced for the aborted count.

## Test plan
- Reset and up-count (WIDTH=8, CHANNELS=2), ch0 limit=3, en=1, auto-reload: Q sequence 0,1,2,3,0,1. terminal high at Q=3. ovf_pulse high one cycle at each Q=0 after 3. ovf_sticky sets on the first wrap and stays high.
- Down one-shot on ch1 (limit=5): load then en=1 gives Q 5,4,3,2,1,0. terminal high at Q=0. Next cycle: done=1, ovf_pulse one cycle, Q stays 0 with en still high. load then restores Q=5 and done=0.
- Sticky flag: ovf_clr pulse alone clears ovf_sticky next cycle. ovf_clr coincident with a wrap event leaves ovf_sticky=1.
- Limit change: up count at Q=10 with limit=20, then limit←4. Next enabled cycle Q=0 with a wrap event. limit=0 gives Q constant 0 and ovf_pulse high every enabled cycle.
- Priority and independence: load and en both high at terminal gives Q=start with no ovf_pulse. en low holds Q. Activity on ch0 leaves ch1 Q and flags unchanged.
- Async reset mid-count: rst asserted between clock edges with ch0 Q=7 and ch1 done=1. All outputs go to 0 before the next edge, and counting resumes from 0 after rst deasserts.
